digit_reverse_reader: RTL
=========================

DIGIT_REVERSE_READER -- requirements
Module: digit_reverse_reader

Interface
REQ-001 SHALL have parameter P_WIDTH, default 64, giving the sample width in bits.
REQ-002 SHALL have parameter P_LOG2N, default 8, giving log2 of the frame length N; legal values are multiples of 4 from 4 to 12.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_data, input, width P_WIDTH: input sample, natural order.
REQ-006 SHALL have port in_valid, input, width 1: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, width 1: block accepts a sample this cycle.
REQ-008 SHALL have port out_data, output, width P_WIDTH: output sample, radix-16 digit-reversed order.
REQ-009 SHALL have port out_valid, output, width 1: out_data is valid this cycle.
REQ-010 SHALL have port out_ready, input, width 1: downstream accepts out_data this cycle.
REQ-011 SHALL have port out_last, output, width 1: high with the final sample of each output frame.

Function
REQ-012 SHALL contain two banks, each holding N samples of P_WIDTH bits, with one full flag per bank.
REQ-013 SHALL define write-side state as write bank wbank (1 bit) and write count wcnt (P_LOG2N bits).
REQ-014 SHALL drive in_ready combinationally as NOT full[wbank].
REQ-015 SHALL accept a sample when in_valid and in_ready are both high, storing in_data at bank[wbank][wcnt] and incrementing wcnt.
REQ-016 SHALL, on acceptance with wcnt = N-1, wrap wcnt to 0, set full[wbank] and toggle wbank at the same edge.
REQ-017 SHALL define read-side state as read bank rbank (1 bit) and read count rcnt (P_LOG2N bits).
REQ-018 SHALL issue a read when full[rbank] is high and (out_valid low or out_ready high).
REQ-019 SHALL read at address digitrev(rcnt): the 4-bit digits of rcnt in reversed order, e.g. {rcnt[3:0],rcnt[7:4]} for P_LOG2N=8.
REQ-020 SHALL register the issued sample into out_data at the issue edge, and set out_valid and out_last (out_last = (rcnt == N-1)) at that same edge.
REQ-021 SHALL, on an issue with rcnt = N-1, wrap rcnt to 0, clear full[rbank] and toggle rbank at the same edge.
REQ-022 SHALL clear out_valid and out_last at an edge where out_valid and out_ready are high and no new read issues.
REQ-023 SHALL hold out_data, out_valid and out_last stable while out_valid is high and out_ready is low.
REQ-024 SHALL give latency from last input accept (edge k) to out_valid high: high after edge k+1 when the output register is free.
REQ-025 SHALL provide no same-cycle bypass from a full flag clear to in_ready: a bank freed at edge e accepts writes from the cycle after e.
REQ-026 SHALL sustain 1 sample/cycle with continuous in_valid and out_ready, keeping in_ready high from reset onward.
REQ-027 SHALL treat a write-bank set and a read-bank clear at the same edge independently, since they are always different banks.
REQ-028 SHALL have no partial-frame flush: an incomplete frame stays pending until it is completed.

Reset
REQ-029 SHALL, when rst is high at an edge, clear wbank, wcnt, rbank, rcnt, both full flags, out_valid and out_last.
REQ-030 SHALL clear out_data to 0 on reset; bank contents are not reset.
REQ-031 SHALL, on reset mid-frame, discard any partial or pending frames; the first accept after reset is sample 0 of a new frame.
REQ-032 SHALL hold in_ready low during cycles with rst high, then high in the first cycle after reset.

Verification
REQ-033 SHALL cover single frame: N=256, in_data = 0..255, out_ready=1 -> outputs 0,16,32,...,240,1,17,...,255, with out_last only on the value 255.
REQ-034 SHALL cover latency: last input accepted at edge k -> out_valid high after edge k+1 with out_data = 0.
REQ-035 SHALL cover streaming: three back-to-back frames, in_valid=out_ready=1 -> in_ready never low, 768 outputs contiguous, each frame reversed.
REQ-036 SHALL cover backpressure: out_ready=0 while three frames are offered -> in_ready falls after 512 accepts; out_data holds 0; releasing out_ready resumes in order with nothing lost or duplicated.
REQ-037 SHALL cover random stall: random in_valid and out_ready (50%) over 10 frames -> output equals the digit-reversed model and out_data is stable under stall.
REQ-038 SHALL cover reset mid-operation: rst pulsed after 100 accepts of frame 2 while frame 1 drains -> out_valid=0 next cycle; a new frame 0..255 then reverses correctly.

Source files
------------

// File: rtl/digit_reverse_reader.sv
// +------------------------------------------------------------------+
// | digit_reverse_reader                                             |
// | Ping-pong frame buffer: natural-order writes, radix-16           |
// | digit-reversed reads with a registered valid/ready output stage. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module digit_reverse_reader #(
  parameter int P_WIDTH = 64,
  parameter int P_LOG2N = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [P_WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [P_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  localparam int                 c_n      = 1 << P_LOG2N;
  localparam int                 c_digits = P_LOG2N / 4;
  localparam logic [P_LOG2N-1:0] c_one    = 1;

  logic [P_WIDTH-1:0] bank_mem [0:2*c_n-1];

  logic               wbank_q, wbank_d;
  logic [P_LOG2N-1:0] wcnt_q, wcnt_d;
  logic               rbank_q, rbank_d;
  logic [P_LOG2N-1:0] rcnt_q, rcnt_d;
  logic [1:0]         full_q, full_d;
  logic [P_WIDTH-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;

  logic               w_accept;
  logic               w_issue;
  logic [P_LOG2N-1:0] w_rev_addr;
  logic [P_WIDTH-1:0] w_rd_data;

  // Reverse the order of the 4-bit digits of the read counter.
  for (genvar d = 0; d < c_digits; d++) begin : g_digit
    assign w_rev_addr[4*d +: 4] = rcnt_q[4*(c_digits-1-d) +: 4];
  end

  assign in_ready  = ~rst & ~full_q[wbank_q];
  assign w_accept  = in_valid & in_ready;
  assign w_issue   = full_q[rbank_q] & (~out_valid_q | out_ready);
  assign w_rd_data = bank_mem[{rbank_q, w_rev_addr}];

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  always_comb begin
    wbank_d     = wbank_q;
    wcnt_d      = wcnt_q;
    rbank_d     = rbank_q;
    rcnt_d      = rcnt_q;
    full_d      = full_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (w_accept) begin
      wcnt_d = wcnt_q + c_one;
      if (&wcnt_q) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end

    // Write and read sides always own different banks, so their flag updates never collide.
    if (w_issue) begin
      out_data_d  = w_rd_data;
      out_valid_d = 1'b1;
      out_last_d  = &rcnt_q;
      rcnt_d      = rcnt_q + c_one;
      if (&rcnt_q) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank_q     <= 1'b0;
      wcnt_q      <= '0;
      rbank_q     <= 1'b0;
      rcnt_q      <= '0;
      full_q      <= 2'b00;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wbank_q     <= wbank_d;
      wcnt_q      <= wcnt_d;
      rbank_q     <= rbank_d;
      rcnt_q      <= rcnt_d;
      full_q      <= full_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      bank_mem[{wbank_q, wcnt_q}] <= in_data;
    end
  end

endmodule

`default_nettype wire
